// File: rtl/control_unit_pkg.sv
// Shared types and constants for the control unit, its decoder and the testbench.
// Holds the FSM state encoding, opcodes, ALU selects and instruction field positions.
package control_unit_pkg;

    localparam int unsigned IrWidth = 16;

    // Instruction field positions
    localparam int unsigned OpcodeMsb  = 15;
    localparam int unsigned OpcodeLsb  = 12;
    localparam int unsigned MemAddrMsb = 11;
    localparam int unsigned MemAddrLsb = 4;
    localparam int unsigned RaMsb      = 11;
    localparam int unsigned RaLsb      = 8;
    localparam int unsigned RbMsb      = 7;
    localparam int unsigned RbLsb      = 4;
    localparam int unsigned RdMsb      = 3;
    localparam int unsigned RdLsb      = 0;

    typedef logic [3:0] opcode_t;

    localparam opcode_t OpNoop  = 4'h0;
    localparam opcode_t OpStore = 4'h1;
    localparam opcode_t OpLoad  = 4'h2;
    localparam opcode_t OpAdd   = 4'h3;
    localparam opcode_t OpSub   = 4'h4;
    localparam opcode_t OpHalt  = 4'h5;

    typedef logic [2:0] alu_sel_t;

    localparam alu_sel_t AluPassA = 3'b000;
    localparam alu_sel_t AluAdd   = 3'b001;
    localparam alu_sel_t AluSub   = 3'b010;

    typedef enum logic [3:0] {
        StInit   = 4'd0,
        StFetch  = 4'd1,
        StDecode = 4'd2,
        StNoop   = 4'd3,
        StLoadA  = 4'd4,
        StLoadB  = 4'd5,
        StStore  = 4'd6,
        StAdd    = 4'd7,
        StSub    = 4'd8,
        StHalt   = 4'd9
    } state_t;

endpackage

// File: rtl/control_unit_if.sv
// Bus between the control unit and the datapath: instruction in, control strobes out.
// The control unit is the master; the datapath (or testbench) is the slave.
interface control_unit_if;
    import control_unit_pkg::*;

    logic [IrWidth-1:0] IR;
    logic               PC_Clr;
    logic               PC_Up;
    logic               IR_Ld;
    logic [7:0]         D_Addr;
    logic               D_Wr;
    logic               RF_s;
    logic [3:0]         RF_W_Addr;
    logic               RF_W_en;
    logic [3:0]         RF_Ra_Addr;
    logic [3:0]         RF_Rb_Addr;
    logic [2:0]         ALU_s0;
    logic [3:0]         OutState;
    logic [3:0]         NextState;

    modport master (
        input  IR,
        output PC_Clr, PC_Up, IR_Ld, D_Addr, D_Wr, RF_s, RF_W_Addr, RF_W_en,
        output RF_Ra_Addr, RF_Rb_Addr, ALU_s0, OutState, NextState
    );

    modport slave (
        output IR,
        input  PC_Clr, PC_Up, IR_Ld, D_Addr, D_Wr, RF_s, RF_W_Addr, RF_W_en,
        input  RF_Ra_Addr, RF_Rb_Addr, ALU_s0, OutState, NextState
    );

endinterface

// File: rtl/instr_decoder.sv
// Combinational instruction decoder: maps the opcode to the state entered after
// DECODE and splits out the address and register fields of the instruction.
module instr_decoder
    import control_unit_pkg::*;
(
    input  logic [IrWidth-1:0] ir,
    output state_t             target,
    output logic [7:0]         mem_addr,
    output logic [3:0]         ra_addr,
    output logic [3:0]         rb_addr,
    output logic [3:0]         rd_addr
);

    opcode_t opcode;

    assign opcode   = ir[OpcodeMsb:OpcodeLsb];
    assign mem_addr = ir[MemAddrMsb:MemAddrLsb];
    assign ra_addr  = ir[RaMsb:RaLsb];
    assign rb_addr  = ir[RbMsb:RbLsb];
    assign rd_addr  = ir[RdMsb:RdLsb];

    // Unassigned opcodes 6..F fall through to NOOP.
    always_comb begin
        target = StNoop;
        case (opcode)
            OpNoop:  target = StNoop;
            OpStore: target = StStore;
            OpLoad:  target = StLoadA;
            OpAdd:   target = StAdd;
            OpSub:   target = StSub;
            OpHalt:  target = StHalt;
            default: target = StNoop;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Moore FSM sequencing fetch/decode/execute for a small 16-bit processor.
// Write and PC strobes are gated by Reset so an aborted instruction never commits.
module control_unit
    import control_unit_pkg::*;
(
    input  logic          Clk,
    input  logic          Reset,
    control_unit_if.master bus
);

    state_t     state_q;
    state_t     state_d;
    state_t     target;
    logic [7:0] mem_addr;
    logic [3:0] ra_addr;
    logic [3:0] rb_addr;
    logic [3:0] rd_addr;

    instr_decoder u_instr_decoder (
        .ir       (bus.IR),
        .target   (target),
        .mem_addr (mem_addr),
        .ra_addr  (ra_addr),
        .rb_addr  (rb_addr),
        .rd_addr  (rd_addr)
    );

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q <= StInit;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StInit:   state_d = StFetch;
            StFetch:  state_d = StDecode;
            StDecode: state_d = target;
            StLoadA:  state_d = StLoadB;
            StLoadB:  state_d = StFetch;
            StNoop:   state_d = StFetch;
            StStore:  state_d = StFetch;
            StAdd:    state_d = StFetch;
            StSub:    state_d = StFetch;
            StHalt:   state_d = StHalt;
            default:  state_d = StInit;
        endcase
        if (!Reset) begin
            state_d = StInit;
        end
    end

    always_comb begin
        bus.PC_Clr     = 1'b0;
        bus.PC_Up      = 1'b0;
        bus.IR_Ld      = 1'b0;
        bus.D_Addr     = 8'h00;
        bus.D_Wr       = 1'b0;
        bus.RF_s       = 1'b0;
        bus.RF_W_Addr  = 4'h0;
        bus.RF_W_en    = 1'b0;
        bus.RF_Ra_Addr = 4'h0;
        bus.RF_Rb_Addr = 4'h0;
        bus.ALU_s0     = AluPassA;
        case (state_q)
            StInit: bus.PC_Clr = 1'b1;
            StFetch: begin
                bus.IR_Ld = 1'b1;
                bus.PC_Up = 1'b1;
            end
            StLoadA: begin
                bus.D_Addr    = mem_addr;
                bus.RF_s      = 1'b1;
                bus.RF_W_Addr = rd_addr;
            end
            // Second LOAD cycle: RAM data is now valid, so commit the write.
            StLoadB: begin
                bus.D_Addr    = mem_addr;
                bus.RF_s      = 1'b1;
                bus.RF_W_Addr = rd_addr;
                bus.RF_W_en   = 1'b1;
            end
            StStore: begin
                bus.D_Addr     = mem_addr;
                bus.RF_Ra_Addr = rd_addr;
                bus.D_Wr       = 1'b1;
            end
            StAdd, StSub: begin
                bus.RF_Ra_Addr = ra_addr;
                bus.RF_Rb_Addr = rb_addr;
                bus.RF_W_Addr  = rd_addr;
                bus.RF_W_en    = 1'b1;
                bus.ALU_s0     = (state_q == StAdd) ? AluAdd : AluSub;
            end
            default: ;
        endcase
        if (!Reset) begin
            bus.IR_Ld   = 1'b0;
            bus.PC_Up   = 1'b0;
            bus.D_Wr    = 1'b0;
            bus.RF_W_en = 1'b0;
        end
    end

    assign bus.OutState  = state_q;
    assign bus.NextState = state_d;

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: the driver pushes the expected outputs of each
// cycle into a queue and a negedge monitor pops and compares them.
module tb_control_unit;
    import control_unit_pkg::*;

    typedef struct packed {
        logic [3:0] st;
        logic [3:0] nx;
        logic       pc_clr;
        logic       pc_up;
        logic       ir_ld;
        logic [7:0] d_addr;
        logic       d_wr;
        logic       rf_s;
        logic [3:0] w_addr;
        logic       w_en;
        logic [3:0] ra;
        logic [3:0] rb;
        logic [2:0] alu;
    } outs_t;

    logic Clk;
    logic Reset;
    control_unit_if bus ();

    control_unit dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    outs_t exp_q[$];
    int    tag_q[$];
    int    checks = 0;
    int    errors = 0;
    int    step_n = 0;

    // Expected outputs straight from the per-state output table.
    function automatic outs_t expect_outs(state_t st, state_t nx, logic [15:0] ir, logic rst);
        outs_t e;
        e    = '0;
        e.st = st;
        e.nx = nx;
        case (st)
            StInit: e.pc_clr = 1'b1;
            StFetch: begin
                e.ir_ld = 1'b1;
                e.pc_up = 1'b1;
            end
            StLoadA, StLoadB: begin
                e.d_addr = ir[11:4];
                e.rf_s   = 1'b1;
                e.w_addr = ir[3:0];
                e.w_en   = (st == StLoadB);
            end
            StStore: begin
                e.d_addr = ir[11:4];
                e.ra     = ir[3:0];
                e.d_wr   = 1'b1;
            end
            StAdd, StSub: begin
                e.ra     = ir[11:8];
                e.rb     = ir[7:4];
                e.w_addr = ir[3:0];
                e.w_en   = 1'b1;
                e.alu    = (st == StAdd) ? 3'b001 : 3'b010;
            end
            default: ;
        endcase
        if (!rst) begin
            e.ir_ld = 1'b0;
            e.pc_up = 1'b0;
            e.d_wr  = 1'b0;
            e.w_en  = 1'b0;
        end
        return e;
    endfunction

    task automatic step(input logic rst, input logic [15:0] ir, input state_t st,
                        input state_t nx);
        @(posedge Clk);
        #1;
        Reset  = rst;
        bus.IR = ir;
        step_n++;
        exp_q.push_back(expect_outs(st, nx, ir, rst));
        tag_q.push_back(step_n);
    endtask

    // Monitor: one output vector per cycle, checked at the falling edge.
    initial begin
        outs_t a;
        outs_t e;
        int    t;
        forever begin
            @(negedge Clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                a = '{st: bus.OutState, nx: bus.NextState, pc_clr: bus.PC_Clr,
                      pc_up: bus.PC_Up, ir_ld: bus.IR_Ld, d_addr: bus.D_Addr,
                      d_wr: bus.D_Wr, rf_s: bus.RF_s, w_addr: bus.RF_W_Addr,
                      w_en: bus.RF_W_en, ra: bus.RF_Ra_Addr, rb: bus.RF_Rb_Addr,
                      alu: bus.ALU_s0};
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL step%0d ir=%h got st=%0d nx=%0d clr=%b up=%b ld=%b da=%h wr=%b s=%b wa=%h we=%b ra=%h rb=%h alu=%b | want st=%0d nx=%0d clr=%b up=%b ld=%b da=%h wr=%b s=%b wa=%h we=%b ra=%h rb=%h alu=%b",
                             t, bus.IR,
                             a.st, a.nx, a.pc_clr, a.pc_up, a.ir_ld, a.d_addr, a.d_wr, a.rf_s,
                             a.w_addr, a.w_en, a.ra, a.rb, a.alu,
                             e.st, e.nx, e.pc_clr, e.pc_up, e.ir_ld, e.d_addr, e.d_wr, e.rf_s,
                             e.w_addr, e.w_en, e.ra, e.rb, e.alu);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1);
    end

    initial begin
        Reset  = 1'b0;
        bus.IR = 16'h0000;

        // Reset held for two edges, then released
        step(1'b0, 16'h0000, StInit, StInit);
        step(1'b0, 16'h0000, StInit, StInit);
        step(1'b1, 16'h0000, StInit, StFetch);

        // ADD r3 = r1 + r2
        step(1'b1, 16'h3123, StFetch,  StDecode);
        step(1'b1, 16'h3123, StDecode, StAdd);
        step(1'b1, 16'h3123, StAdd,    StFetch);

        // LOAD r5 <= mem[1A], two execute cycles
        step(1'b1, 16'h21A5, StFetch,  StDecode);
        step(1'b1, 16'h21A5, StDecode, StLoadA);
        step(1'b1, 16'h21A5, StLoadA,  StLoadB);
        step(1'b1, 16'h21A5, StLoadB,  StFetch);

        // STORE mem[0F] <= r7
        step(1'b1, 16'h10F7, StFetch,  StDecode);
        step(1'b1, 16'h10F7, StDecode, StStore);
        step(1'b1, 16'h10F7, StStore,  StFetch);

        // Illegal opcode behaves as NOOP
        step(1'b1, 16'hF000, StFetch,  StDecode);
        step(1'b1, 16'hF000, StDecode, StNoop);
        step(1'b1, 16'hF000, StNoop,   StFetch);

        // SUB r1 = rA - rB
        step(1'b1, 16'h4AB1, StFetch,  StDecode);
        step(1'b1, 16'h4AB1, StDecode, StSub);
        step(1'b1, 16'h4AB1, StSub,    StFetch);

        // Explicit NOOP
        step(1'b1, 16'h0000, StFetch,  StDecode);
        step(1'b1, 16'h0000, StDecode, StNoop);
        step(1'b1, 16'h0000, StNoop,   StFetch);

        // Reset while in LOAD_A
        step(1'b1, 16'h21A5, StFetch,  StDecode);
        step(1'b1, 16'h21A5, StDecode, StLoadA);
        step(1'b0, 16'h21A5, StLoadA,  StInit);
        step(1'b1, 16'h21A5, StInit,   StFetch);

        // Reset while in LOAD_B must suppress the register write
        step(1'b1, 16'h2347, StFetch,  StDecode);
        step(1'b1, 16'h2347, StDecode, StLoadA);
        step(1'b1, 16'h2347, StLoadA,  StLoadB);
        step(1'b0, 16'h2347, StLoadB,  StInit);
        step(1'b1, 16'h2347, StInit,   StFetch);

        // Reset during FETCH must suppress IR_Ld and PC_Up
        step(1'b0, 16'h0000, StFetch,  StInit);
        step(1'b1, 16'h0000, StInit,   StFetch);

        // HALT holds with no strobes, then reset exits it
        step(1'b1, 16'h5000, StFetch,  StDecode);
        step(1'b1, 16'h5000, StDecode, StHalt);
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 16'h5000, StHalt, StHalt);
        end
        step(1'b0, 16'h5000, StHalt, StInit);
        step(1'b1, 16'h5000, StInit, StFetch);
        step(1'b1, 16'h5000, StFetch, StDecode);

        @(negedge Clk);
        @(negedge Clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
